// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake, flush to BUBBLE, saturating stall counter.
// Optional skid entry (macro PIPE_STAGE_SKID_EN) registers in_ready for full throughput under back-pressure.
`timescale 1ns/1ps
module pipe_stage_reg #(
    parameter int               WIDTH  = 96,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_free;
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_skid_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign w_in_fire   = in_valid && w_in_ready;
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_main_free = !r_out_valid || w_out_fire;

`ifdef PIPE_STAGE_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    // in_ready comes straight from a flop, cutting the out_ready -> in_ready path
    assign w_in_ready   = !r_skid_valid;
    assign w_skid_valid = r_skid_valid;
    assign w_skid_data  = r_skid_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
        end else if (w_main_free && r_skid_valid) begin
            r_skid_valid <= 1'b0;
        end else if (!w_main_free && w_in_fire) begin
            r_skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_main_free && w_in_fire) begin
            r_skid_data <= in_data;
        end
    end
`else
    assign w_in_ready   = w_main_free;
    assign w_skid_valid = 1'b0;
    assign w_skid_data  = BUBBLE;
`endif

    // Main register: skid entry drains ahead of new input to preserve order
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= BUBBLE;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_out_data  <= BUBBLE;
        end else if (w_main_free) begin
            if (w_skid_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_skid_data;
            end else if (w_in_fire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: streaming vector table, scoreboard, back-pressure/flush/saturation sequences.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

    localparam logic [15:0] BUB = 16'hB0B0;
`ifdef PIPE_STAGE_SKID_EN
    localparam logic EXP_IR_C1 = 1'b1;
`else
    localparam logic EXP_IR_C1 = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        flush;
    logic [3:0]  stall_cnt;

    pipe_stage_reg #(.WIDTH(16), .BUBBLE(BUB), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        exp_ov;
        logic [15:0] exp_od;
        logic        exp_ir;
    } vec_t;

    vec_t        vecs[10];
    logic [15:0] q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          n_push = 0;
    logic        g_in_fire;
    logic        g_out_fire;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Sample at the falling edge, then update the scoreboard for the coming rising edge
    task automatic sample();
        logic [15:0] e;
        @(negedge clk);
        g_in_fire  = in_valid && in_ready;
        g_out_fire = out_valid && out_ready;
        if (reset) begin
            if (g_out_fire) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_spurious: got %0h expected no output", out_data);
                end else begin
                    e = q.pop_front();
                    chk("sb_order", {16'h0, out_data}, {16'h0, e});
                    n_pop++;
                end
            end
            if (flush) q.delete();
            else if (g_in_fire) begin
                q.push_back(in_data);
                n_push++;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q.delete();
        adv();
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int pops0;
        logic [15:0] nxt;

        for (int k = 0; k < 10; k++) begin
            vecs[k].iv     = (k < 8);
            vecs[k].id     = (k < 8) ? 16'(k + 1) : 16'h0;
            vecs[k].ordy   = 1'b1;
            vecs[k].exp_ov = (k >= 1 && k <= 8);
            vecs[k].exp_od = (k == 0) ? BUB : (k == 9) ? 16'd8 : 16'(k);
            vecs[k].exp_ir = 1'b1;
        end

        reset = 1'b0; in_valid = 0; in_data = 0; out_ready = 0; flush = 0;
        adv(); adv();
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_data", {16'h0, out_data}, {16'h0, BUB});
        chk("rst_cnt", {28'h0, stall_cnt}, 32'h0);
        chk("rst_ready", {31'h0, in_ready}, 32'h1);
        reset = 1'b1;

        for (int k = 0; k < 10; k++) begin
            in_valid = vecs[k].iv; in_data = vecs[k].id; out_ready = vecs[k].ordy;
            sample();
            chk($sformatf("stream_ov[%0d]", k), {31'h0, out_valid}, {31'h0, vecs[k].exp_ov});
            chk($sformatf("stream_od[%0d]", k), {16'h0, out_data}, {16'h0, vecs[k].exp_od});
            chk($sformatf("stream_ir[%0d]", k), {31'h0, in_ready}, {31'h0, vecs[k].exp_ir});
            adv();
        end

        // Asynchronous reset with a payload held
        in_valid = 1; in_data = 16'h55; out_ready = 1;
        sample();
        adv();
        in_valid = 0; out_ready = 0;
        chk("rstmid_pre_valid", {31'h0, out_valid}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        chk("rstmid_valid", {31'h0, out_valid}, 32'h0);
        chk("rstmid_data", {16'h0, out_data}, {16'h0, BUB});
        chk("rstmid_cnt", {28'h0, stall_cnt}, 32'h0);
        chk("rstmid_ready", {31'h0, in_ready}, 32'h1);
        adv();
        reset = 1'b1;

        // Back-pressure: three stalled cycles with payload 1 at the output
        nxt = 1; c = 0; n_pop = 0;
        while ((nxt <= 6 || q.size() != 0) && c < 40) begin
            in_valid = (nxt <= 6); in_data = nxt; out_ready = !(c >= 1 && c <= 3);
            sample();
            if (c == 1) chk("bp_ready_c1", {31'h0, in_ready}, {31'h0, EXP_IR_C1});
            if (c == 2) chk("bp_ready_c2", {31'h0, in_ready}, 32'h0);
            if (c == 3) chk("bp_ready_c3", {31'h0, in_ready}, 32'h0);
            if (c == 4) begin
                chk("bp_cnt", {28'h0, stall_cnt}, 32'd3);
                chk("bp_head", {16'h0, out_data}, 32'd1);
            end
            if (g_in_fire) nxt++;
            adv();
            c++;
        end
        in_valid = 0;
        chk("bp_delivered", n_pop, 6);

        // Flush with main (and skid, when built) full and a new payload offered
        pops0 = n_pop;
        in_valid = 1; in_data = 16'hA1; out_ready = 0; sample(); adv();
        in_data = 16'hA2; sample(); adv();
        in_data = 16'hA3; flush = 1; sample(); adv();
        in_valid = 0; flush = 0; out_ready = 1;
        sample();
        chk("flush_valid", {31'h0, out_valid}, 32'h0);
        chk("flush_data", {16'h0, out_data}, {16'h0, BUB});
        chk("flush_ready", {31'h0, in_ready}, 32'h1);
        adv();
        for (int k = 0; k < 4; k++) begin
            sample(); adv();
        end
        chk("flush_none_out", n_pop, pops0);

        // Flush coinciding with an output transfer
        in_valid = 1; in_data = 16'hC1; out_ready = 1; sample(); adv();
        pops0 = n_pop;
        in_data = 16'hC2; flush = 1; sample(); adv();
        in_valid = 0; flush = 0;
        chk("flushfire_consumed", n_pop, pops0 + 1);
        sample();
        chk("flushfire_valid", {31'h0, out_valid}, 32'h0);
        chk("flushfire_data", {16'h0, out_data}, {16'h0, BUB});
        adv();

        // Counter saturation at 15, untouched by flush
        do_reset();
        in_valid = 1; in_data = 16'h77; out_ready = 0; sample(); adv();
        in_valid = 0;
        for (int k = 1; k <= 20; k++) begin
            sample();
            if (k == 10) chk("sat_mid", {28'h0, stall_cnt}, 32'd9);
            adv();
        end
        sample();
        chk("sat_cnt", {28'h0, stall_cnt}, 32'd15);
        flush = 1; adv();
        flush = 0;
        sample();
        chk("sat_after_flush", {28'h0, stall_cnt}, 32'd15);
        chk("sat_flush_valid", {31'h0, out_valid}, 32'h0);
        adv();

        // Random handshakes
        do_reset();
        n_pop = 0; n_push = 0; nxt = 16'h100;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = nxt;
            out_ready = ($urandom_range(0, 3) != 0);
            sample();
            if (g_in_fire) nxt++;
            adv();
        end
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 10 && q.size() != 0; k++) begin
            sample(); adv();
        end
        chk("rand_drained", q.size(), 0);
        chk("rand_count", n_pop, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic parametrised pipeline stage register with a valid/ready handshake, synchronous flush with bubble insertion, and a saturating back-pressure counter. It replaces the fixed-field, enable-only stage registers between the fetch, decode, execute, memory and writeback stages. Each boundary instantiates one copy with the concatenated stage payload as `in_data`. An optional skid entry breaks the combinational ready path so that full throughput is kept under back-pressure.

## Interface
Parameters:
- `WIDTH`, default 96: payload width in bits. The default covers instr + pc + pcplus4.
- `BUBBLE`, default 0: payload value driven on `out_data` after reset or flush. For example, a NOP in the instruction field.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset. 0 resets the block; 1 is normal operation.
- `in_valid`  in  1: upstream presents a valid payload.
- `in_ready`  out  1: the stage can accept a payload this cycle.
- `in_data`  in  WIDTH: upstream payload.
- `out_valid`  out  1: the stage holds a valid payload.
- `out_ready`  in  1: downstream accepts the payload this cycle.
- `out_data`  out  WIDTH: payload held by the stage.
- `flush`  in  1: synchronous kill of all held and incoming payloads.
- `stall_cnt`  out  CNT_W: saturating count of back-pressured cycles.

## Operation
- **Handshakes.**
  - Input transfer (in_fire) occurs when `in_valid && in_ready`.
  - Output transfer (out_fire) occurs when `out_valid && out_ready`.
  - `in_data` is sampled only on in_fire. `out_data` is stable while `out_valid && !out_ready`.
- **Storage.** The main register holds `out_valid`/`out_data`. The optional skid register holds `skid_valid`/`skid_data` (see Configuration).
- **Update rules, in priority order, evaluated each rising edge:**
  1. `flush` = 1:
     - `out_valid` <= 0, `skid_valid` <= 0, `out_data` <= `BUBBLE`.
     - A payload that fires in this cycle is consumed and discarded.
  2. Main register empty, or out_fire:
     - If `skid_valid`, main <= skid and `skid_valid` <= 0. A concurrent in_fire is impossible in this case because `in_ready` = 0.
     - Else if in_fire, main <= `in_data` and `out_valid` <= 1.
     - Else `out_valid` <= 0 and `out_data` holds its last value.
  3. Main register full, no out_fire, in_fire: skid <= `in_data`, `skid_valid` <= 1 (skid build only).
- **Ordering.** Payload order is strictly preserved. No payload is duplicated or dropped except by `flush`.
- **Stall counter.**
  - `stall_cnt` increments by 1 in each cycle where `out_valid && !out_ready`.
  - It saturates at 2^CNT_W−1.
  - It is cleared only by `reset`; `flush` does not clear it.

## Timing
- **Reset.** While `reset` = 0, the following hold asynchronously:
  - `out_valid` = 0, `skid_valid` = 0, `out_data` = `BUBBLE`, `stall_cnt` = 0.
  - `in_ready` = 1.
- **Latency.** 1 cycle: data accepted at edge N is visible on `out_data` after edge N.
- **Throughput.** 1 payload/cycle sustained when `out_ready` is held at 1.
- **Back-pressure.** `out_ready` = 0 with the main register full: the first extra accepted payload goes to skid, and `in_ready` falls the next cycle.
- **Recovery.** `out_ready` returning to 1 with skid full: the skid payload moves to main on that edge, and `in_ready` = 1 in the following cycle.
- **Flush interactions.**
  - `flush` together with out_fire in the same cycle: the downstream still consumes the current payload, and the state is still cleared.
  - `flush` takes effect on the same edge, and `in_ready` = 1 in the next cycle.
- **Reset mid-transfer.** Reset asserted mid-transfer aborts it immediately. No payload survives.

## Configuration
- **`PIPE_STAGE_SKID_EN` defined:**
  - The skid register is present.
  - `in_ready` = `!skid_valid`, taken directly from a flop, with no combinational path from `out_ready`.
- **`PIPE_STAGE_SKID_EN` undefined:**
  - No skid register is built; rule 3 never applies.
  - `in_ready` = `!out_valid || out_ready` (combinational).
  - Latency, ordering, flush and counter behaviour are identical to the skid build.

## Test plan
- **Reset:** assert `reset` = 0 mid-stream with `out_valid` = 1 → immediately `out_valid` = 0, `out_data` = `BUBBLE`, `stall_cnt` = 0, `in_ready` = 1.
- **Streaming:** present payloads 1..8 back-to-back with `out_ready` = 1 → `out_data` = 1..8 on consecutive cycles, 1-cycle latency, no gaps.
- **Back-pressure:** stream 1..6, hold `out_ready` = 0 for 3 cycles starting with payload 1 at the output → skid build: 2 is captured in skid, `in_ready` = 0, `stall_cnt` = 3, and 1..6 are then delivered in order; non-skid build: `in_ready` = 0 in each stalled cycle, same order.
- **Flush:** assert `flush` with main and skid full and `in_valid` = 1 → next cycle `out_valid` = 0, `out_data` = `BUBBLE`, and none of the three payloads ever appears at the output.
- **Counter saturation:** `CNT_W` = 4, hold `out_valid` = 1 and `out_ready` = 0 for 20 cycles → `stall_cnt` stops at 15; a following `flush` leaves it at 15.
- **Random ordering:** randomised `in_valid`/`out_ready` for 10000 cycles, in both macro builds → the scoreboard sees every payload exactly once and in order.
